// File: rtl/raster_addr_gen.sv
// Row-major raster walker for rectangular draw regions. Emits x/y draw
// coordinates and the matching linear read address, with optional mirroring.
module raster_addr_gen #(
    parameter int WIDTH  = 40,
    parameter int HEIGHT = 40,
    parameter int XW     = 6,
    parameter int YW     = 6,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              advance,
    input  logic              flipX,
    output logic              busy,
    output logic [XW-1:0]     x,
    output logic [YW-1:0]     y,
    output logic [ADDR_W-1:0] addr,
    output logic              last,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [XW-1:0]     X_MAX    = XW'(WIDTH - 1);
    localparam logic [YW-1:0]     Y_MAX    = YW'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIDTH);

    state_t              state, state_nxt;
    logic [XW-1:0]       x_nxt;
    logic [YW-1:0]       y_nxt;
    logic [ADDR_W-1:0]   row_base, row_base_nxt;
    logic                flip, flip_nxt;
    logic [XW-1:0]       x_eff;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt    = state;
        x_nxt        = x;
        y_nxt        = y;
        row_base_nxt = row_base;
        flip_nxt     = flip;

        case (state)
            S_IDLE: begin
                if (start) begin
                    flip_nxt     = flipX;
                    x_nxt        = '0;
                    y_nxt        = '0;
                    row_base_nxt = '0;
                    state_nxt    = S_RUN;
                end
            end
            S_RUN: begin
                if (advance) begin
                    if (x != X_MAX) begin
                        x_nxt = x + XW'(1);
                    end else if (y != Y_MAX) begin
                        // Row wrap: rowBase tracks y*WIDTH by accumulation, no multiplier.
                        x_nxt        = '0;
                        y_nxt        = y + YW'(1);
                        row_base_nxt = row_base + ROW_STEP;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            x        <= '0;
            y        <= '0;
            row_base <= '0;
            flip     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            x        <= x_nxt;
            y        <= y_nxt;
            row_base <= row_base_nxt;
            flip     <= flip_nxt;
            busy     <= (state_nxt == S_RUN);
            done     <= (state_nxt == S_DONE);
        end
    end

    // Mirroring reflects only the column offset; rows still advance top to bottom.
    assign x_eff = flip ? (X_MAX - x) : x;
    assign addr  = row_base + ADDR_W'(x_eff);
    assign last  = busy && (x == X_MAX) && (y == Y_MAX);

endmodule

// File: tb/tb_raster_addr_gen.sv
// Scoreboard bench for raster_addr_gen: a 4x3 instance for walk/mirror/pacing/reset
// scenarios and a default 40x40 instance for back-to-back walks.
module tb_raster_addr_gen;

    typedef struct {
        int x;
        int y;
        int addr;
        bit last;
    } pix_t;

    logic        clk = 1'b0;
    logic        resetn;

    logic        start_s, advance_s, flip_s;
    logic        busy_s, last_s, done_s;
    logic [1:0]  x_s, y_s;
    logic [3:0]  addr_s;

    logic        start_b, advance_b, flip_b;
    logic        busy_b, last_b, done_b;
    logic [5:0]  x_b, y_b;
    logic [10:0] addr_b;

    int   n_checks = 0;
    int   n_fails  = 0;
    pix_t sb[$];
    int   sb_addr[$];

    always #5 clk = ~clk;

    raster_addr_gen #(
        .WIDTH(4), .HEIGHT(3), .XW(2), .YW(2), .ADDR_W(4)
    ) u_small (
        .clk(clk), .resetn(resetn), .start(start_s), .advance(advance_s),
        .flipX(flip_s), .busy(busy_s), .x(x_s), .y(y_s), .addr(addr_s),
        .last(last_s), .done(done_s)
    );

    raster_addr_gen u_big (
        .clk(clk), .resetn(resetn), .start(start_b), .advance(advance_b),
        .flipX(flip_b), .busy(busy_b), .x(x_b), .y(y_b), .addr(addr_b),
        .last(last_b), .done(done_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (busy_s !== 1'b0 || done_s !== 1'b0 || last_s !== 1'b0) begin
                n_fails++;
                $display("FAIL reset_flags: got busy=%b done=%b last=%b required 0 0 0", busy_s, done_s, last_s);
            end
            n_checks++;
            if (x_s !== 2'd0 || y_s !== 2'd0 || addr_s !== 4'd0) begin
                n_fails++;
                $display("FAIL reset_coords: got x=%0d y=%0d addr=%0d required 0 0 0", x_s, y_s, addr_s);
            end
            n_checks++;
            if (busy_b !== 1'b0 || done_b !== 1'b0 || addr_b !== 11'd0) begin
                n_fails++;
                $display("FAIL reset_big: got busy=%b done=%b addr=%0d required 0 0 0", busy_b, done_b, addr_b);
            end
        end
    endtask

    // Drives one 4x3 walk from a start pulse (cycle 0) and scores every cycle
    // against the expected pixel list; returns the cycle at which done was seen.
    task automatic run_small_walk(input bit flip, input bit pace, input bit poke, output int done_cyc);
        pix_t p;
        sb.delete();
        for (int yy = 0; yy < 3; yy++) begin
            for (int xx = 0; xx < 4; xx++) begin
                p.x    = xx;
                p.y    = yy;
                p.addr = yy * 4 + (flip ? 3 - xx : xx);
                p.last = (xx == 3 && yy == 2);
                sb.push_back(p);
            end
        end
        done_cyc  = -1;
        start_s   = 1'b1;
        flip_s    = flip;
        advance_s = 1'b1;
        tick();
        start_s = 1'b0;
        flip_s  = ~flip;
        for (int c = 1; c < 200; c++) begin
            if (sb.size() > 0) begin
                n_checks++;
                if (busy_s !== 1'b1 || done_s !== 1'b0) begin
                    n_fails++;
                    $display("FAIL walk_busy c=%0d: got busy=%b done=%b required 1 0", c, busy_s, done_s);
                end
                n_checks++;
                if (x_s !== sb[0].x || y_s !== sb[0].y || addr_s !== sb[0].addr || last_s !== sb[0].last) begin
                    n_fails++;
                    $display("FAIL walk_pixel c=%0d: got x=%0d y=%0d addr=%0d last=%b required x=%0d y=%0d addr=%0d last=%b",
                             c, x_s, y_s, addr_s, last_s, sb[0].x, sb[0].y, sb[0].addr, sb[0].last);
                end
                advance_s = pace ? (c % 2 == 0) : 1'b1;
                start_s   = poke && (c == 5);
                if (advance_s) p = sb.pop_front();
            end else begin
                n_checks++;
                if (busy_s !== 1'b0 || done_s !== 1'b1) begin
                    n_fails++;
                    $display("FAIL walk_done c=%0d: got busy=%b done=%b required 0 1", c, busy_s, done_s);
                end
                done_cyc = c;
                break;
            end
            tick();
        end
        start_s   = 1'b0;
        advance_s = 1'b0;
        if (done_cyc < 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL walk_timeout: got no done within 200 cycles required done");
        end
        tick();
        n_checks++;
        if (busy_s !== 1'b0 || done_s !== 1'b0) begin
            n_fails++;
            $display("FAIL walk_idle_after: got busy=%b done=%b required 0 0", busy_s, done_s);
        end
    endtask

    task automatic test_full_walk;
        int dc;
        run_small_walk(1'b0, 1'b0, 1'b0, dc);
        n_checks++;
        if (dc !== 13) begin
            n_fails++;
            $display("FAIL full_walk_done_cycle: got %0d required 13", dc);
        end
    endtask

    task automatic test_mirror;
        int dc;
        run_small_walk(1'b1, 1'b0, 1'b0, dc);
        n_checks++;
        if (dc !== 13) begin
            n_fails++;
            $display("FAIL mirror_done_cycle: got %0d required 13", dc);
        end
    endtask

    task automatic test_pacing;
        int dc;
        run_small_walk(1'b0, 1'b1, 1'b1, dc);
        n_checks++;
        if (dc !== 25) begin
            n_fails++;
            $display("FAIL pacing_done_cycle: got %0d required 25", dc);
        end
    endtask

    task automatic test_reset_mid;
        int dc;
        start_s   = 1'b1;
        flip_s    = 1'b1;
        advance_s = 1'b1;
        tick();
        start_s = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (busy_s !== 1'b1 || x_s !== 2'd2 || y_s !== 2'd1 || addr_s !== 4'd5) begin
            n_fails++;
            $display("FAIL mid_pixel: got busy=%b x=%0d y=%0d addr=%0d required 1 2 1 5", busy_s, x_s, y_s, addr_s);
        end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        n_checks++;
        if (busy_s !== 1'b0 || done_s !== 1'b0 || x_s !== 2'd0 || y_s !== 2'd0 || addr_s !== 4'd0) begin
            n_fails++;
            $display("FAIL mid_reset: got busy=%b done=%b x=%0d y=%0d addr=%0d required 0 0 0 0 0",
                     busy_s, done_s, x_s, y_s, addr_s);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (busy_s !== 1'b0 || done_s !== 1'b0) begin
                n_fails++;
                $display("FAIL mid_no_done: got busy=%b done=%b required 0 0", busy_s, done_s);
            end
        end
        flip_s = 1'b0;
        run_small_walk(1'b0, 1'b0, 1'b0, dc);
        n_checks++;
        if (dc !== 13) begin
            n_fails++;
            $display("FAIL mid_rewalk_done_cycle: got %0d required 13", dc);
        end
    endtask

    task automatic test_back_to_back;
        int done_cyc;
        int a;
        done_cyc = -1;
        sb_addr.delete();
        for (int i = 0; i < 1600; i++) sb_addr.push_back(i);
        start_b   = 1'b1;
        advance_b = 1'b1;
        flip_b    = 1'b0;
        tick();
        for (int c = 1; c < 5000; c++) begin
            if (sb_addr.size() > 0) begin
                n_checks++;
                if (busy_b !== 1'b1 || addr_b !== sb_addr[0] || last_b !== (sb_addr.size() == 1)) begin
                    n_fails++;
                    $display("FAIL b2b_pixel c=%0d: got busy=%b addr=%0d last=%b required 1 %0d %b",
                             c, busy_b, addr_b, last_b, sb_addr[0], sb_addr.size() == 1);
                end
                a = sb_addr.pop_front();
            end else begin
                n_checks++;
                if (busy_b !== 1'b0 || done_b !== 1'b1 || addr_b !== 11'd1599) begin
                    n_fails++;
                    $display("FAIL b2b_done c=%0d: got busy=%b done=%b addr=%0d required 0 1 1599",
                             c, busy_b, done_b, addr_b);
                end
                done_cyc = c;
                break;
            end
            tick();
        end
        if (done_cyc < 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL b2b_timeout: got no done within 5000 cycles required done");
        end
        tick();
        n_checks++;
        if (busy_b !== 1'b0 || done_b !== 1'b0) begin
            n_fails++;
            $display("FAIL b2b_idle_gap: got busy=%b done=%b required 0 0", busy_b, done_b);
        end
        tick();
        n_checks++;
        if (busy_b !== 1'b1 || done_b !== 1'b0 || addr_b !== 11'd0 || x_b !== 6'd0 || y_b !== 6'd0) begin
            n_fails++;
            $display("FAIL b2b_restart: got busy=%b done=%b addr=%0d x=%0d y=%0d required 1 0 0 0 0",
                     busy_b, done_b, addr_b, x_b, y_b);
        end
        start_b   = 1'b0;
        advance_b = 1'b0;
    endtask

    initial begin
        resetn    = 1'b0;
        start_s   = 1'b0;
        advance_s = 1'b0;
        flip_s    = 1'b0;
        start_b   = 1'b0;
        advance_b = 1'b0;
        flip_b    = 1'b0;
        test_reset();
        test_full_walk();
        test_mirror();
        test_pacing();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
